// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bus initiator and its responders.
package reg_bus_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int TRIES_W    = 5;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_READ    = 2'b01,
        OP_POLL    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RWAIT,
        ST_GAP,
        ST_RSP
    } state_t;

    // Register map of the responder this initiator normally talks to
    localparam int unsigned REG_DATA0 = 'h0;
    localparam int unsigned REG_SR0   = 'h4;
    localparam int unsigned REG_DATA1 = 'h8;
    localparam int unsigned REG_SR1   = 'hC;

endpackage

// File: rtl/reg_bus_poll_cmp.sv
// Read-attempt bookkeeping for the bus master: saturating tries counter,
// inter-poll gap down-counter, masked compare and retry-limit decision.
module reg_bus_poll_cmp
    import reg_bus_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int POLL_MAX = 16,
    parameter int POLL_GAP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               rd_issue,
    input  logic               gap_run,
    input  logic [DATA_W-1:0]  rdata,
    input  logic [DATA_W-1:0]  expected,
    input  logic [DATA_W-1:0]  mask,
    output logic               match,
    output logic               timeout,
    output logic               gap_done,
    output logic [TRIES_W-1:0] tries
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries   <= '0;
            gap_cnt <= '0;
        end else begin
            if (clear)
                tries <= '0;
            else if (rd_issue && (tries != '1))
                tries <= tries + 1'b1;

            // Held at the load value outside GAP so the count starts fresh on entry
            if (!gap_run)
                gap_cnt <= GAP_INIT;
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - 1'b1;
        end
    end

    assign gap_done = (gap_cnt == '0);
    assign match    = (((rdata ^ expected) & mask) == '0);
    assign timeout  = ({{(32-TRIES_W){1'b0}}, tries} >= 32'(POLL_MAX));

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: one command at a time from a valid/ready channel,
// turned into single-cycle wr_en/rd_en strobes, result returned on a response channel.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int POLL_MAX = 16,
    parameter int POLL_GAP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    input  logic [DATA_W-1:0]  cmd_mask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic [TRIES_W-1:0] rsp_tries,
    output logic               wr_en,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  addr,
    output logic [DATA_W-1:0]  wdata,
    input  logic [DATA_W-1:0]  rdata
);

    // state    | meaning
    // ST_IDLE  | cmd_ready high, waiting for a command
    // ST_WR    | wr_en pulse on the bus
    // ST_RD    | rd_en pulse on the bus
    // ST_RWAIT | waiting RD_LAT cycles for rdata, then decide
    // ST_GAP   | idle spacing between POLL reads
    // ST_RSP   | response held until rsp_ready

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    state_t               state;
    op_t                  op_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    exp_q;
    logic [DATA_W-1:0]    mask_q;
    logic [LAT_W-1:0]     wait_cnt;

    logic                 accept;
    logic                 rd_issue;
    logic                 gap_run;
    logic                 poll_match;
    logic                 poll_timeout;
    logic                 gap_done;
    logic [TRIES_W-1:0]   tries;

    assign accept   = (state == ST_IDLE) && cmd_valid;
    assign rd_issue = (state == ST_RD);
    assign gap_run  = (state == ST_GAP);

    reg_bus_poll_cmp #(
        .DATA_W   (DATA_W),
        .POLL_MAX (POLL_MAX),
        .POLL_GAP (POLL_GAP)
    ) u_poll_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .rd_issue (rd_issue),
        .gap_run  (gap_run),
        .rdata    (rdata),
        .expected (exp_q),
        .mask     (mask_q),
        .match    (poll_match),
        .timeout  (poll_timeout),
        .gap_done (gap_done),
        .tries    (tries)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_WRITE;
            addr_q    <= '0;
            exp_q     <= '0;
            mask_q    <= '0;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_tries <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        addr_q    <= cmd_addr;
                        exp_q     <= cmd_wdata;
                        mask_q    <= cmd_mask;
                        cmd_ready <= 1'b0;
                        case (op_t'(cmd_op))
                            OP_WRITE: begin
                                wr_en <= 1'b1;
                                addr  <= cmd_addr;
                                wdata <= cmd_wdata;
                                state <= ST_WR;
                            end
                            OP_READ, OP_POLL: begin
                                rd_en <= 1'b1;
                                addr  <= cmd_addr;
                                state <= ST_RD;
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                rsp_rdata <= '0;
                                rsp_err   <= 1'b1;
                                rsp_tries <= '0;
                                state     <= ST_RSP;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    wr_en     <= 1'b0;
                    addr      <= '0;
                    wdata     <= '0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    rsp_tries <= '0;
                    state     <= ST_RSP;
                end
                ST_RD: begin
                    rd_en    <= 1'b0;
                    addr     <= '0;
                    wait_cnt <= LAT_INIT;
                    state    <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else if ((op_q != OP_POLL) || poll_match || poll_timeout) begin
                        // The limit is only consulted after the compare of the last read
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
                        rsp_err   <= (op_q == OP_POLL) && !poll_match;
                        rsp_tries <= tries;
                        state     <= ST_RSP;
                    end else if (POLL_GAP == 0) begin
                        rd_en <= 1'b1;
                        addr  <= addr_q;
                        state <= ST_RD;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        rd_en <= 1'b1;
                        addr  <= addr_q;
                        state <= ST_RD;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        rsp_tries <= '0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    wr_en     <= 1'b0;
                    rd_en     <= 1'b0;
                    addr      <= '0;
                    wdata     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: bench-side register responder, command-level model,
// directed cases from the plan followed by randomized command streams.
module tb_reg_bus_master;
    import reg_bus_pkg::*;

    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int RD_LAT   = 1;
    localparam int POLL_MAX = 16;
    localparam int POLL_GAP = 2;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] cmd_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [4:0]    rsp_tries;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    reg_bus_master #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_tries(rsp_tries),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic          busy = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    logic          ready_at_edge = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Responder: DATA0/DATA1 store writes; writing SR0/SR1 snapshots DATA0/DATA1.
    logic [DW-1:0] r_data0, r_sr0, r_data1, r_sr1;
    logic [DW-1:0] pipe [RD_LAT];

    function automatic logic [DW-1:0] r_read(input logic [AW-1:0] a);
        case (a)
            10'h0:   return r_data0;
            10'h4:   return r_sr0;
            10'h8:   return r_data1;
            10'hC:   return r_sr1;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_sr0   <= '0;
            r_data1 <= '1;
            r_sr1   <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            if (wr_en) begin
                case (addr)
                    10'h0: r_data0 <= wdata;
                    10'h4: r_sr0   <= r_data0;
                    10'h8: r_data1 <= wdata;
                    10'hC: r_sr1   <= r_data1;
                    default: ;
                endcase
            end
            if (rd_en) pipe[0] <= r_read(addr);
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign rdata = pipe[RD_LAT-1];

    // Command-level model of the register contents
    logic [DW-1:0] m_data0, m_sr0, m_data1, m_sr1;

    task automatic m_reset();
        m_data0 = '0; m_sr0 = '0; m_data1 = '1; m_sr1 = '0;
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        case (a)
            10'h0:   return m_data0;
            10'h4:   return m_sr0;
            10'h8:   return m_data1;
            10'hC:   return m_sr1;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) ready_at_edge = rsp_ready;

    // Per-cycle bus and channel rules
    logic          pv = 1'b0;
    logic [DW+5:0] prev_rsp = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", 64'(wr_en & rd_en), 64'd0);
            if (!wr_en && !rd_en) chk("idle_bus", 64'({addr, wdata}), 64'd0);
            if (wr_en) begin
                chk("wr_addr", 64'(addr), 64'(cur_addr));
                chk("wr_data", 64'(wdata), 64'(cur_wdata));
            end
            if (rd_en) chk("rd_addr", 64'(addr), 64'(cur_addr));
            chk("cmd_ready", 64'(cmd_ready), 64'(!busy));
            if (pv && !ready_at_edge) begin
                chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
                chk("rsp_hold_data", 64'({rsp_rdata, rsp_err, rsp_tries}), 64'(prev_rsp));
            end
            pv       = rsp_valid;
            prev_rsp = {rsp_rdata, rsp_err, rsp_tries};
        end else begin
            pv = 1'b0;
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] mk, input int hold,
                           output logic [DW-1:0] o_rdata, output logic o_err, output logic [4:0] o_tries);
        logic [DW-1:0] e_rdata = '0;
        logic          e_err   = 1'b0;
        int            e_tries = 0, e_lat = 0, e_reads = 0, e_writes = 0;
        int            k = 0, rdc = 0, wrc = 0, last = 0;
        logic          done = 1'b0;
        case (op)
            2'b00: begin
                e_lat = 1; e_writes = 1;
                case (a)
                    10'h0: m_data0 = wd;
                    10'h4: m_sr0   = m_data0;
                    10'h8: m_data1 = wd;
                    10'hC: m_sr1   = m_data1;
                    default: ;
                endcase
            end
            2'b01: begin
                e_rdata = m_read(a); e_tries = 1; e_reads = 1; e_lat = 1 + RD_LAT;
            end
            2'b10: begin
                e_rdata = m_read(a);
                e_reads = (((e_rdata ^ wd) & mk) == '0) ? 1 : POLL_MAX;
                e_err   = (e_reads != 1) || (POLL_MAX == 1 && ((e_rdata ^ wd) & mk) != '0);
                e_tries = (e_reads > 31) ? 31 : e_reads;
                e_lat   = e_reads * (1 + RD_LAT) + (e_reads - 1) * POLL_GAP;
            end
            default: e_err = 1'b1;
        endcase

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
        @(posedge clk);
        busy = 1'b1; cur_addr = a; cur_wdata = wd;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom);
                cmd_wdata = $urandom; cmd_mask = $urandom;
            end
            if (rsp_valid) begin
                done = 1'b1;
                break;
            end
            if (rd_en) begin
                if (rdc > 0) chk("rd_spacing", 64'(k - last), 64'(1 + RD_LAT + POLL_GAP));
                rdc++;
                last = k;
            end
            if (wr_en) wrc++;
            k++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL rsp_wait actual=no_response required=response op=%0d", op);
        end
        chk("latency", 64'(k), 64'(e_lat));
        chk("rd_pulses", 64'(rdc), 64'(e_reads));
        chk("wr_pulses", 64'(wrc), 64'(e_writes));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("rsp_tries", 64'(rsp_tries), 64'(e_tries));
        o_rdata = rsp_rdata; o_err = rsp_err; o_tries = rsp_tries;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        busy = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    logic [DW-1:0] r;
    logic          e;
    logic [4:0]    t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
        cmd_wdata = '0; cmd_mask = '0; rsp_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_strobes", 64'({wr_en, rd_en}), 64'd0);
        chk("rst_bus", 64'({addr, wdata, rsp_rdata, rsp_err, rsp_tries}), 64'd0);
        #1 rst_n = 1'b1;

        run_cmd(2'b01, 10'h8, '0, '0, 0, r, e, t);
        chk("pin_read8", 64'(r), 64'hFFFF_FFFF);
        chk("pin_read8_tries", 64'(t), 64'd1);
        run_cmd(2'b01, 10'h0, '0, '0, 0, r, e, t);
        chk("pin_read0", 64'(r), 64'h0);
        run_cmd(2'b00, 10'h0, 32'hA5A5_A5A5, '0, 0, r, e, t);
        chk("pin_write_rdata", 64'(r), 64'h0);
        run_cmd(2'b00, 10'h4, 32'h0BAD_F00D, '0, 1, r, e, t);
        run_cmd(2'b01, 10'h4, '0, '0, 0, r, e, t);
        chk("pin_sr0", 64'(r), 64'hA5A5_A5A5);
        run_cmd(2'b00, 10'h0, 32'h1234_A5A5, '0, 0, r, e, t);
        run_cmd(2'b10, 10'h0, 32'h0000_A5A5, 32'h0000_FFFF, 0, r, e, t);
        chk("pin_poll_match", 64'({r, e, t}), 64'({32'h1234_A5A5, 1'b0, 5'd1}));
        run_cmd(2'b10, 10'h10, 32'h1, 32'hFFFF_FFFF, 0, r, e, t);
        chk("pin_poll_timeout", 64'({r, e, t}), 64'({32'h0, 1'b1, 5'd16}));
        run_cmd(2'b01, 10'h0, '0, '0, 5, r, e, t);
        chk("pin_hold_read", 64'(r), 64'h1234_A5A5);
        run_cmd(2'b11, 10'h8, 32'hFFFF_FFFF, '0, 0, r, e, t);
        chk("pin_illegal", 64'({r, e, t}), 64'({32'h0, 1'b1, 5'd0}));
        run_cmd(2'b10, 10'h8, 32'h0, 32'h0, 0, r, e, t);
        chk("pin_mask0", 64'({e, t}), 64'({1'b0, 5'd1}));
        run_cmd(2'b00, 10'h8, 32'h1234_5678, '0, 0, r, e, t);
        run_cmd(2'b01, 10'h8, '0, '0, 0, r, e, t);
        chk("pin_data1", 64'(r), 64'h1234_5678);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]    op;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, mk;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 10'h0;
                1: a = 10'h4;
                2: a = 10'h8;
                3: a = 10'hC;
                4: a = 10'h10;
                default: a = AW'($urandom);
            endcase
            wd = $urandom;
            case ($urandom_range(0, 2))
                0: mk = '0;
                1: mk = '1;
                default: mk = $urandom;
            endcase
            if (op == 2'b10 && $urandom_range(0, 1) == 1) wd = m_read(a) ^ (~mk & $urandom);
            run_cmd(op, a, wd, mk, int'($urandom_range(0, 3)), r, e, t);
        end

        // Reset during the third read of a timing-out POLL
        begin
            int nrd = 0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 10'h10; cmd_wdata = 32'h1; cmd_mask = '1;
            @(posedge clk);
            busy = 1'b1; cur_addr = 10'h10;
            for (int i = 0; i < 500 && nrd < 3; i++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                if (rd_en) nrd++;
            end
            chk("rst_reached_read3", 64'(nrd), 64'd3);
            #1 rst_n = 1'b0;
            busy = 1'b0;
            m_reset();
            #1;
            chk("async_strobes", 64'({wr_en, rd_en}), 64'd0);
            chk("async_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("async_cmd_ready", 64'(cmd_ready), 64'd1);
            chk("async_addr", 64'(addr), 64'd0);
            @(negedge clk);
            #1 rst_n = 1'b1;
        end
        run_cmd(2'b01, 10'h8, '0, '0, 0, r, e, t);
        chk("pin_after_reset", 64'({r, e, t}), 64'({32'hFFFF_FFFF, 1'b0, 5'd1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
